// File: rtl/prm_edge_mask_engine.sv
// rtl/prm_edge_mask_engine.sv - programmable cube-table edge mask engine for PRM collision pruning
// Scans one sum-of-products cube per cycle and ORs matching cubes into per-obstacle mask bits.
module prm_edge_mask_engine #(
    parameter int CFG_W     = 15,
    parameter int NUM_OBS   = 8,
    parameter int NUM_TERMS = 64,
    parameter int ID_W      = 10,
    localparam int AW       = $clog2(NUM_TERMS),
    localparam int OW       = $clog2(NUM_OBS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [CFG_W-1:0]   cfg_care,
    input  logic [CFG_W-1:0]   cfg_val,
    input  logic [OW-1:0]      cfg_obs,
    input  logic               cfg_en,
    output logic               cfg_err,
    input  logic [NUM_OBS-1:0] obs_enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [CFG_W-1:0]   in_code,
    input  logic [ID_W-1:0]    in_id,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_id,
    output logic [NUM_OBS-1:0] out_mask,
    output logic               out_blocked,
    output logic               busy
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    localparam logic [AW-1:0] LAST = AW'(NUM_TERMS - 1);

    state_t             state_q, state_d;
    logic [CFG_W-1:0]   code_q, code_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [NUM_OBS-1:0] snap_en_q, snap_en_d;
    logic [NUM_OBS-1:0] acc_q, acc_d;
    logic [AW-1:0]      k_q, k_d;
    logic               cfg_err_q, cfg_err_d;

    logic [CFG_W-1:0]   care_q   [NUM_TERMS];
    logic [CFG_W-1:0]   care_d   [NUM_TERMS];
    logic [CFG_W-1:0]   val_q    [NUM_TERMS];
    logic [CFG_W-1:0]   val_d    [NUM_TERMS];
    logic [OW-1:0]      obs_q    [NUM_TERMS];
    logic [OW-1:0]      obs_d    [NUM_TERMS];
    logic               ent_en_q [NUM_TERMS];
    logic               ent_en_d [NUM_TERMS];

    logic                 tbl_wr;
    logic                 match;
    logic [(1<<OW)-1:0]   obs_dec;
    logic [NUM_OBS-1:0]   hit_vec;
    logic [NUM_OBS-1:0]   acc_next;

    assign tbl_wr = cfg_we && (state_q == S_IDLE);

    always_comb begin
        care_d   = care_q;
        val_d    = val_q;
        obs_d    = obs_q;
        ent_en_d = ent_en_q;
        if (tbl_wr) begin
            care_d[cfg_addr]   = cfg_care;
            val_d[cfg_addr]    = cfg_val;
            obs_d[cfg_addr]    = cfg_obs;
            ent_en_d[cfg_addr] = cfg_en;
        end
    end

    // Channel decode is sized to the full obs field, so out-of-range channels fall off the slice.
    assign match    = ent_en_q[k_q] && (((code_q ^ val_q[k_q]) & care_q[k_q]) == '0);
    assign obs_dec  = {{((1 << OW) - 1){1'b0}}, 1'b1} << obs_q[k_q];
    assign hit_vec  = obs_dec[NUM_OBS-1:0] & snap_en_q & {NUM_OBS{match}};
    assign acc_next = acc_q | hit_vec;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        id_d      = id_q;
        snap_en_d = snap_en_q;
        acc_d     = acc_q;
        k_d       = k_q;
        cfg_err_d = cfg_we && (state_q != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    code_d    = in_code;
                    id_d      = in_id;
                    snap_en_d = obs_enable;
                    acc_d     = '0;
                    k_d       = '0;
                    state_d   = S_SCAN;
                end
            end
            S_SCAN: begin
                acc_d = acc_next;
                k_d   = k_q + AW'(1);
                if ((k_q == LAST) ||
                    ((snap_en_q != '0) && ((acc_next & snap_en_q) == snap_en_q))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            id_q      <= '0;
            snap_en_q <= '0;
            acc_q     <= '0;
            k_q       <= '0;
            cfg_err_q <= 1'b0;
            for (int i = 0; i < NUM_TERMS; i++) begin
                care_q[i]   <= '0;
                val_q[i]    <= '0;
                obs_q[i]    <= '0;
                ent_en_q[i] <= 1'b0;
            end
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            id_q      <= id_d;
            snap_en_q <= snap_en_d;
            acc_q     <= acc_d;
            k_q       <= k_d;
            cfg_err_q <= cfg_err_d;
            care_q    <= care_d;
            val_q     <= val_d;
            obs_q     <= obs_d;
            ent_en_q  <= ent_en_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_mask    = out_valid ? acc_q : '0;
    assign out_blocked = out_valid && (acc_q != '0);
    assign out_id      = id_q;
    assign busy        = (state_q != S_IDLE);
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// tb/tb_prm_edge_mask_engine.sv - directed table-driven bench for prm_edge_mask_engine
module tb_prm_edge_mask_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [5:0]  cfg_addr;
    logic [14:0] cfg_care;
    logic [14:0] cfg_val;
    logic [2:0]  cfg_obs;
    logic        cfg_en;
    logic        cfg_err;
    logic [7:0]  obs_enable;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_code;
    logic [9:0]  in_id;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_id;
    logic [7:0]  out_mask;
    logic        out_blocked;
    logic        busy;

    int checks = 0;
    int errors = 0;

    prm_edge_mask_engine dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_care(cfg_care), .cfg_val(cfg_val),
        .cfg_obs(cfg_obs), .cfg_en(cfg_en), .cfg_err(cfg_err),
        .obs_enable(obs_enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_id(in_id),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_mask(out_mask), .out_blocked(out_blocked), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_load;
        logic [5:0]  addr;
        logic [14:0] care;
        logic [14:0] val;
        logic [2:0]  obs;
        bit          ent_en;
        logic [7:0]  obs_en;
        logic [14:0] code;
        logic [9:0]  id;
        logic [7:0]  mask;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_entry(input logic [5:0] a, input logic [14:0] c, input logic [14:0] v,
                              input logic [2:0] o, input bit e);
        cfg_we = 1'b1; cfg_addr = a; cfg_care = c; cfg_val = v; cfg_obs = o; cfg_en = e;
        @(posedge clk); #1 cfg_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_edge(input logic [14:0] c, input logic [9:0] id, input logic [7:0] en);
        in_code = c; in_id = id; obs_enable = en; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat, output bit to);
        lat = 1; to = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            if (lat > 200) begin to = 1'b1; break; end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic wait_result(output logic [7:0] m, output logic [9:0] id, output logic b,
                               output int lat, output bit to);
        wait_valid(lat, to);
        m = out_mask; id = out_id; b = out_blocked;
        @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        logic [7:0] m; logic [9:0] id; logic b; int lat; bit to;
        if (v.do_load) load_entry(v.addr, v.care, v.val, v.obs, v.ent_en);
        start_edge(v.code, v.id, v.obs_en);
        wait_result(m, id, b, lat, to);
        chk($sformatf("v%0d_timeout", n), 32'(to), 32'd0);
        chk($sformatf("v%0d_mask", n), 32'(m), 32'(v.mask));
        chk($sformatf("v%0d_blocked", n), 32'(b), 32'(v.mask != 8'h00));
        chk($sformatf("v%0d_id", n), 32'(id), 32'(v.id));
        chk($sformatf("v%0d_latency", n), 32'(lat), 32'(v.lat));
    endtask

    initial begin
        logic [7:0] m; logic [9:0] id; logic b; int lat; bit to; bit bad;

        vecs[0] = '{1'b1, 6'd0,  15'h63D8, 15'h4208, 3'd2, 1'b1, 8'h04, 15'h4208, 10'd5,  8'h04, 2};
        vecs[1] = '{1'b0, 6'd0,  15'h0000, 15'h0000, 3'd0, 1'b0, 8'h04, 15'h4209, 10'd6,  8'h04, 2};
        vecs[2] = '{1'b0, 6'd0,  15'h0000, 15'h0000, 3'd0, 1'b0, 8'h04, 15'h4308, 10'd7,  8'h00, 65};
        vecs[3] = '{1'b1, 6'd0,  15'h0000, 15'h0000, 3'd1, 1'b1, 8'h0A, 15'h0000, 10'd8,  8'h02, 65};
        vecs[4] = '{1'b1, 6'd63, 15'h0000, 15'h0000, 3'd3, 1'b1, 8'h0A, 15'h0000, 10'd9,  8'h0A, 65};
        vecs[5] = '{1'b0, 6'd0,  15'h0000, 15'h0000, 3'd0, 1'b0, 8'h02, 15'h0000, 10'd10, 8'h02, 2};
        vecs[6] = '{1'b0, 6'd0,  15'h0000, 15'h0000, 3'd0, 1'b0, 8'h00, 15'h0000, 10'd11, 8'h00, 65};
        vecs[7] = '{1'b1, 6'd5,  15'h7FFF, 15'h1234, 3'd5, 1'b1, 8'h20, 15'h1234, 10'd12, 8'h20, 7};
        vecs[8] = '{1'b0, 6'd0,  15'h0000, 15'h0000, 3'd0, 1'b0, 8'h22, 15'h1234, 10'd13, 8'h22, 7};
        vecs[9] = '{1'b0, 6'd0,  15'h0000, 15'h0000, 3'd0, 1'b0, 8'h22, 15'h1235, 10'd14, 8'h02, 65};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_care = '0; cfg_val = '0; cfg_obs = '0;
        cfg_en = 1'b0; obs_enable = '0; in_valid = 1'b0; in_code = '0; in_id = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_mask", 32'(out_mask), 32'd0);
        chk("rst_out_blocked", 32'(out_blocked), 32'd0);
        chk("rst_out_id", 32'(out_id), 32'd0);
        chk("rst_cfg_err", 32'(cfg_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Back-pressure: result must hold and no new edge may be taken while DONE is stalled.
        out_ready = 1'b0;
        start_edge(15'h1234, 10'd20, 8'h22);
        wait_valid(lat, to);
        chk("bp_timeout", 32'(to), 32'd0);
        in_valid = 1'b1; in_code = 15'h0000; in_id = 10'd21; obs_enable = 8'h01;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_mask !== 8'h22 || out_id !== 10'd20 || in_ready) bad = 1'b1;
        end
        chk("bp_hold", 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_valid_drop", 32'(out_valid), 32'd0);
        @(posedge clk); #1 in_valid = 1'b0;
        wait_result(m, id, b, lat, to);
        chk("bp2_id", 32'(id), 32'd21);
        chk("bp2_mask", 32'(m), 32'd0);
        chk("bp2_latency", 32'(lat), 32'd65);

        // Config write while scanning is dropped and flagged.
        start_edge(15'h1235, 10'd30, 8'h22);
        @(negedge clk);
        chk("scan_busy", 32'(busy), 32'd1);
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_care = '0; cfg_val = '0; cfg_obs = 3'd1; cfg_en = 1'b0;
        @(posedge clk); #1 cfg_we = 1'b0;
        @(negedge clk);
        chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
        @(negedge clk);
        chk("cfg_err_clear", 32'(cfg_err), 32'd0);
        @(posedge clk); #1;
        wait_result(m, id, b, lat, to);
        chk("drop_run_mask", 32'(m), 32'h02);
        start_edge(15'h1235, 10'd31, 8'h22);
        wait_result(m, id, b, lat, to);
        chk("drop_rerun_mask", 32'(m), 32'h02);

        // Write and accept on the same edge: the new entry is seen by that scan.
        cfg_we = 1'b1; cfg_addr = 6'd6; cfg_care = 15'h7FFF; cfg_val = 15'h1235; cfg_obs = 3'd4; cfg_en = 1'b1;
        in_valid = 1'b1; in_code = 15'h1235; in_id = 10'd40; obs_enable = 8'h10;
        @(posedge clk); #1 begin cfg_we = 1'b0; in_valid = 1'b0; end
        wait_result(m, id, b, lat, to);
        chk("same_edge_mask", 32'(m), 32'h10);
        chk("same_edge_latency", 32'(lat), 32'd8);

        // Reset mid-scan aborts the result and empties the table.
        start_edge(15'h4208, 10'd50, 8'h04);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_edge(15'h4208, 10'd51, 8'h04);
        wait_result(m, id, b, lat, to);
        chk("postrst_timeout", 32'(to), 32'd0);
        chk("postrst_mask", 32'(m), 32'd0);
        chk("postrst_blocked", 32'(b), 32'd0);
        chk("postrst_latency", 32'(lat), 32'd65);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
